// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
// Nibble width, the decoder's blank code and the scan state encoding.
package display_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

endpackage

// File: rtl/scan_slot_counter.sv
// Per-slot cycle counter: clear wins over increment, flags decode the current count.
// Flags are combinational from the count register; no backpressure.
module scan_slot_counter #(
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_CYCLES    = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic blank_done,
  output logic slot_done
);

  localparam int CNT_W = $clog2(TICKS_PER_DIGIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign blank_done = (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign slot_done  = (cnt == CNT_W'(TICKS_PER_DIGIT - 1));

endmodule

// File: rtl/display_scan_mux.sv
// Scans NUM_DIGITS latched BCD digits onto one decoder with a dead-time blank per slot; all outputs registered.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros of the latched frame; no backpressure, en_i=0 aborts next edge.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_CYCLES    = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic [BCD_W*NUM_DIGITS-1:0]   digits_i,
  output logic [BCD_W-1:0]              bcd_o,
  output logic [NUM_DIGITS-1:0]         anode_n_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic                          frame_tick_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  scan_state_t                          state;
  logic [IDX_W-1:0]                     idx;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]     shadow;
  logic                                 blank_done;
  logic                                 slot_done;
  logic                                 cnt_clr;
  logic                                 cnt_inc;
  logic [BCD_W-1:0]                     drive_nib;
  logic [NUM_DIGITS-1:0]                slot_sel;

  // Counter is held at zero outside a scan and restarts at every slot boundary.
  assign cnt_clr = !en_i || (state == IDLE) || ((state == DRIVE) && slot_done);
  assign cnt_inc = (state != IDLE);

  scan_slot_counter #(
    .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
    .BLANK_CYCLES    (BLANK_CYCLES)
  ) u_slot_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  zero_run;

  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run && (shadow[i] == '0);
      lz_blank[i] = zero_run && (i != 0);
    end
    drive_nib = lz_blank[idx] ? BCD_BLANK : shadow[idx];
  end
`else
  always_comb begin
    drive_nib = shadow[idx];
  end
`endif

  always_comb begin
    slot_sel = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      shadow       <= {NUM_DIGITS{BCD_BLANK}};
      bcd_o        <= BCD_BLANK;
      anode_n_o    <= '1;
      frame_tick_o <= 1'b0;
    end else begin
      frame_tick_o <= 1'b0;
      if (!en_i) begin
        state     <= IDLE;
        idx       <= '0;
        bcd_o     <= BCD_BLANK;
        anode_n_o <= '1;
      end else begin
        case (state)
          IDLE: begin
            shadow       <= digits_i;
            frame_tick_o <= 1'b1;
            idx          <= '0;
            state        <= BLANK;
          end
          BLANK: begin
            if (blank_done) begin
              state     <= DRIVE;
              anode_n_o <= ~slot_sel;
              bcd_o     <= drive_nib;
            end
          end
          DRIVE: begin
            if (slot_done) begin
              state     <= BLANK;
              anode_n_o <= '1;
              bcd_o     <= BCD_BLANK;
              // Frame boundary: the only point where new digits become visible.
              if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                idx          <= '0;
                shadow       <= digits_i;
                frame_tick_o <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          default: begin
            state     <= IDLE;
            idx       <= '0;
            bcd_o     <= BCD_BLANK;
            anode_n_o <= '1;
          end
        endcase
      end
    end
  end

  assign digit_idx_o = idx;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with NUM_DIGITS=4, TICKS_PER_DIGIT=8, BLANK_CYCLES=2.
module tb_display_scan_mux;

  localparam int N = 4;
  localparam int T = 8;
  localparam int B = 2;
  localparam int FRAME = N * T;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i;
  logic [15:0] digits_i;
  logic [3:0]  bcd_o;
  logic [3:0]  anode_n_o;
  logic [1:0]  digit_idx_o;
  logic        frame_tick_o;

  int applied = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] digits;
    logic [15:0] exp_nib;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  display_scan_mux #(
    .NUM_DIGITS      (N),
    .TICKS_PER_DIGIT (T),
    .BLANK_CYCLES    (B)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .digits_i     (digits_i),
    .bcd_o        (bcd_o),
    .anode_n_o    (anode_n_o),
    .digit_idx_o  (digit_idx_o),
    .frame_tick_o (frame_tick_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int k, input logic [3:0] ea,
                       input logic [3:0] eb, input logic [1:0] ei, input logic et);
    applied++;
    if ({anode_n_o, bcd_o, digit_idx_o, frame_tick_o} !== {ea, eb, ei, et}) begin
      miscompares++;
      $display("FAIL %s k=%0d: got anode=%b bcd=%h idx=%0d tick=%b, want anode=%b bcd=%h idx=%0d tick=%b",
               name, k, anode_n_o, bcd_o, digit_idx_o, frame_tick_o, ea, eb, ei, et);
    end
  endtask

  // Called one cycle after the edge that sampled en_i high in IDLE (k=0).
  task automatic run_scan(input string name, input logic [15:0] exp_a, input logic [15:0] exp_b,
                          input int last_k, input int switch_k, input logic [15:0] d_sw);
    for (int k = 0; k <= last_k; k++) begin
      int s;
      int p;
      logic [15:0] e;
      logic [3:0] sel;
      s = (k % FRAME) / T;
      p = k % T;
      e = (k < FRAME) ? exp_a : exp_b;
      sel = 4'b0001 << s;
      if (p < B)
        check(name, k, 4'b1111, 4'hF, 2'(s), (k % FRAME) == 0);
      else
        check(name, k, ~sel, e[4*s +: 4], 2'(s), 1'b0);
      if (k == switch_k) digits_i = d_sw;
      if (k < last_k) step();
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h1234};
    vecs[1] = '{16'hA000, 16'hA000};
    vecs[2] = '{16'h9F07, 16'h9F07};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[3] = '{16'h0050, 16'hFF50};
    vecs[4] = '{16'h0000, 16'hFFF0};
`else
    vecs[3] = '{16'h0050, 16'h0050};
    vecs[4] = '{16'h0000, 16'h0000};
`endif

    rst_n    = 1'b0;
    en_i     = 1'b1;
    digits_i = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset", i, 4'b1111, 4'hF, 2'd0, 1'b0);
    end

    rst_n = 1'b1;
    step();
    run_scan("scan_1234", 16'h1234, 16'h1234, 2 * FRAME, -1, 16'h0);

    en_i = 1'b0;
    step();
    check("disable_idle", 0, 4'b1111, 4'hF, 2'd0, 1'b0);
    digits_i = 16'h1234;
    en_i = 1'b1;
    step();
    run_scan("tear_free", 16'h1234, 16'h5678, 2 * FRAME - 1, 10, 16'h5678);

    step();
    step();
    step();
    check("drive_before_drop", 66, 4'b1110, 4'h8, 2'd0, 1'b0);
    en_i = 1'b0;
    step();
    check("drop_en", 0, 4'b1111, 4'hF, 2'd0, 1'b0);
    step();
    check("idle_hold", 1, 4'b1111, 4'hF, 2'd0, 1'b0);
    en_i = 1'b1;
    step();
    run_scan("restart", 16'h5678, 16'h5678, 12, -1, 16'h0);

    for (int i = 0; i < 5; i++) begin
      en_i = 1'b0;
      step();
      check($sformatf("vec%0d_idle", i), 0, 4'b1111, 4'hF, 2'd0, 1'b0);
      digits_i = vecs[i].digits;
      en_i = 1'b1;
      step();
      run_scan($sformatf("vec%0d", i), vecs[i].exp_nib, vecs[i].exp_nib, FRAME, -1, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Time-multiplexes NUM_DIGITS packed BCD digits onto one shared 7-segment decoder and a common-anode digit bank.
- Sits directly upstream of the BCD-to-7seg decoder. bcd_o[3:0] drives the decoder's {a,b,c,d} inputs; anode_n_o drives the digit enables.
- Inserts a dead-time blank between digit slots to suppress ghosting.
- Latches the digit word once per frame, so a frame never mixes old and new values.

Parameters:
- NUM_DIGITS, 4, number of scanned digits (2..8).
- TICKS_PER_DIGIT, 50000, clock cycles per digit slot (>= 4).
- BLANK_CYCLES, 500, all-anodes-off cycles at the start of each slot (1..TICKS_PER_DIGIT-1).
- CNT_W, $clog2(TICKS_PER_DIGIT), localparam, slot counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- en_i  input  1  scan enable.
- digits_i  input  4*NUM_DIGITS  packed BCD; digits_i[3:0] = digit 0 (least significant).
- bcd_o  output  4  nibble for the decoder; bit 3 = a, bit 0 = d.
- anode_n_o  output  NUM_DIGITS  active-low digit enables, one-hot-low or all ones.
- digit_idx_o  output  $clog2(NUM_DIGITS)  index of the current slot.
- frame_tick_o  output  1  one-cycle pulse when the shadow register is loaded.

Behaviour:
- One clock domain; reset is synchronous and active-low; all outputs come from flops.
- Reset values:
  - state = IDLE
  - cnt = 0
  - idx = 0
  - shadow = all 4'hF
  - bcd_o = 4'hF
  - anode_n_o = all ones
  - digit_idx_o = 0
  - frame_tick_o = 0
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - anode_n_o all ones; bcd_o = 4'hF; cnt and idx held at 0.
  - On en_i=1: load shadow from digits_i, pulse frame_tick_o, go to BLANK with cnt=0 and idx=0.
- BLANK:
  - anode_n_o all ones; bcd_o = 4'hF; cnt increments.
  - When cnt = BLANK_CYCLES-1, go to DRIVE.
- DRIVE:
  - anode_n_o[idx]=0, all other bits 1; bcd_o = shadow[idx].
  - cnt increments. At cnt = TICKS_PER_DIGIT-1: cnt <- 0, idx <- idx+1, go to BLANK.
  - If idx = NUM_DIGITS-1 at that point: idx wraps to 0, shadow reloads from digits_i, frame_tick_o pulses.
- Timing: if en_i is sampled high at edge E0:
  - first anode asserts after edge E0+BLANK_CYCLES;
  - it stays low for TICKS_PER_DIGIT-BLANK_CYCLES cycles;
  - frame period = NUM_DIGITS*TICKS_PER_DIGIT cycles.
- digits_i changes mid-frame are invisible until the next frame-boundary reload.
- Nibbles 4'hA..4'hF pass through unchanged; the decoder blanks them.
- en_i=0 in any state: next edge returns to IDLE. Outputs are blanked and counters cleared in the same cycle. No partial slot completes.
- Reset mid-scan has the same effect as IDLE entry and also clears the shadow to all 4'hF.
- Scan order is always 0,1,...,NUM_DIGITS-1, then wraps to 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in DRIVE, digit i>0 shows bcd_o=4'hF if shadow[i] and all more-significant digits are 4'h0. The anode still asserts, so brightness duty is unchanged. Digit 0 is never blanked. Suppression is evaluated on the shadow, not on digits_i.
- Undefined: every digit shows its shadow nibble verbatim.

Decomposition:
- Package display_pkg holds:
  - BCD_BLANK = 4'hF
  - scan state enum {IDLE, BLANK, DRIVE}
  - BCD_W = 4
- One natural sub-module, scan_slot_counter:
  - CNT_W counter with clear and enable inputs;
  - outputs blank_done (cnt = BLANK_CYCLES-1) and slot_done (cnt = TICKS_PER_DIGIT-1).

Test Plan (NUM_DIGITS=4, TICKS_PER_DIGIT=8, BLANK_CYCLES=2 unless noted):
- Reset: rst_n=0 for 3 edges with en_i=1 -> anode_n_o=4'b1111, bcd_o=4'hF, digit_idx_o=0, frame_tick_o=0 throughout.
- Scan: digits_i=16'h1234, en_i=1 -> frame_tick_o pulses once, then repeating slots:
  - anode_n_o=1111 for 2 cycles, then 1110 with bcd_o=4 for 6 cycles;
  - then 1101/3, 1011/2, 0111/1 in the same pattern;
  - frame_tick_o repeats every 32 cycles.
- Tear-free: switch digits_i to 16'h5678 during digit-1 DRIVE -> digits 2 and 3 still show 2 and 1; next frame shows 8, 7, 6, 5.
- Disable/restart: drop en_i during DRIVE -> next cycle anode_n_o=1111 and bcd_o=4'hF. Raise en_i again -> restart at digit 0 with a 2-cycle blank and a frame_tick_o pulse.
- Out-of-range nibble: digits_i=16'hA000 -> digit 3 slot drives bcd_o=4'hA with anode_n_o=0111.
- LEADING_ZERO_BLANK_EN:
  - 16'h0050 -> digits 3 and 2 show bcd_o=4'hF, digit 1 shows 5, digit 0 shows 0;
  - 16'h0000 -> only digit 0 shows 0.
